// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I control definitions for the ID->EX boundary: opcodes, ValidReg bit
// positions, ALUOp/RegSrc encodings and the packed control bundle.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int VR_RD  = 0;
  localparam int VR_RS1 = 1;
  localparam int VR_RS2 = 2;

  typedef enum logic [1:0] {
    ALU_DECODE = 2'd0,
    ALU_ADD    = 2'd1,
    ALU_SUB    = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_PC_IMM = 2'd2,
    SRC_PC4    = 2'd3
  } reg_src_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] reg_src;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use detector: the instruction in EX is a load whose
// nonzero destination is read by the instruction offered from ID.
module id_ex_hazard #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_writes_rd,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            id_valid,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  output logic            load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_valid & ex_mem_read & ex_writes_rd & (ex_rd != '0) &
                    id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and flush.
// Optional ID_EX_PERF_EN adds saturating bubble/flush counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [2:0]      id_valid_reg,
  input  logic [1:0]      id_alu_op,
  input  logic [1:0]      id_reg_src,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_jump,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [2:0]      ex_valid_reg,
  output logic [1:0]      ex_alu_op,
  output logic [1:0]      ex_reg_src,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_bubble_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  // Handshake: ID->stage transfers on id_valid & id_ready; stage->EX transfers
  // on ex_valid & ex_ready. id_ready never waits on id_valid except through load_use.
  logic  valid_q;
  ctrl_t ctrl_q;
  ctrl_t ctrl_d;
  logic  free;
  logic  load_use;
  logic  transfer;

  assign ctrl_d = '{alu_op: id_alu_op, reg_src: id_reg_src, alu_src: id_alu_src,
                    reg_write: id_reg_write, mem_read: id_mem_read,
                    mem_write: id_mem_write, branch: id_branch, jump: id_jump};

  assign free     = ~valid_q | ex_ready;
  assign id_ready = free & ~load_use & ~flush;
  assign transfer = id_valid & id_ready;

  id_ex_hazard #(.RA_W(RA_W)) u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_writes_rd(ex_valid_reg[VR_RD]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_valid_reg[VR_RS1]),
    .id_uses_rs2 (id_valid_reg[VR_RS2]),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_valid_reg <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q      <= 1'b1;
      ctrl_q       <= ctrl_d;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7b5  <= id_funct7b5;
      ex_valid_reg <= id_valid_reg;
    end else if (free) begin
      valid_q <= 1'b0;
    end
  end

  // Side-effecting controls are masked so a bubble or killed slot can never commit.
  assign ex_valid     = valid_q;
  assign ex_alu_op    = ctrl_q.alu_op;
  assign ex_reg_src   = ctrl_q.reg_src;
  assign ex_alu_src   = ctrl_q.alu_src;
  assign ex_reg_write = ctrl_q.reg_write & valid_q;
  assign ex_mem_read  = ctrl_q.mem_read  & valid_q;
  assign ex_mem_write = ctrl_q.mem_write & valid_q;
  assign ex_branch    = ctrl_q.branch    & valid_q;
  assign ex_jump      = ctrl_q.jump      & valid_q;

`ifdef ID_EX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (free & load_use & ~flush & (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
      if (flush & valid_q & (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush scenarios plus randomized traffic
// against a transaction-level model of the held EX slot.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [2:0]  valid_reg;
    logic [1:0]  alu_op;
    logic [1:0]  reg_src;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } instr_t;

  localparam int K_ADD = 0, K_LW = 1, K_SW = 2, K_LUI = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, id_valid, id_ready, ex_valid, ex_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3, id_valid_reg;
  logic        id_funct7b5, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
  logic [1:0]  id_alu_op, id_reg_src;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3, ex_valid_reg;
  logic        ex_funct7b5, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]  ex_alu_op, ex_reg_src;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instr_t      cur_id;
  instr_t      m;
  bit          m_valid;
  logic [31:0] m_bub, m_flu;
  logic        seen_ready;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_valid_reg(id_valid_reg), .id_alu_op(id_alu_op),
    .id_reg_src(id_reg_src), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_valid_reg(ex_valid_reg), .ex_alu_op(ex_alu_op),
    .ex_reg_src(ex_reg_src), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump)
`ifdef ID_EX_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int kind, input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '0;
    i.pc       = $urandom();
    i.rs1_data = $urandom();
    i.rs2_data = $urandom();
    i.imm      = $urandom();
    i.rd       = 5'(rd);
    i.rs1      = 5'(rs1);
    i.rs2      = 5'(rs2);
    i.funct3   = 3'($urandom_range(0, 7));
    i.funct7b5 = 1'($urandom_range(0, 1));
    case (kind)
      K_ADD: begin i.valid_reg = 3'b111; i.reg_write = 1'b1; end
      K_LW:  begin i.valid_reg = 3'b011; i.reg_write = 1'b1; i.mem_read = 1'b1;
                   i.alu_src = 1'b1; i.alu_op = 2'd1; i.reg_src = 2'd1; end
      K_SW:  begin i.valid_reg = 3'b110; i.mem_write = 1'b1; i.alu_src = 1'b1; i.alu_op = 2'd1; end
      K_LUI: begin i.valid_reg = 3'b001; i.reg_write = 1'b1; i.alu_src = 1'b1; end
      K_BR:  begin i.valid_reg = 3'b110; i.branch = 1'b1; i.alu_op = 2'd2; end
      K_JAL: begin i.valid_reg = 3'b001; i.jump = 1'b1; i.reg_write = 1'b1; i.reg_src = 2'd3; end
      default: ;
    endcase
    return i;
  endfunction

  function automatic instr_t obs_bundle();
    instr_t o;
    o = '{pc: ex_pc, rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm,
          rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, funct3: ex_funct3, funct7b5: ex_funct7b5,
          valid_reg: ex_valid_reg, alu_op: ex_alu_op, reg_src: ex_reg_src,
          alu_src: ex_alu_src, reg_write: ex_reg_write, mem_read: ex_mem_read,
          mem_write: ex_mem_write, branch: ex_branch, jump: ex_jump};
    return o;
  endfunction

  // What EX should show: the held instruction, with commit-type controls masked when empty.
  function automatic instr_t exp_bundle();
    instr_t e;
    e = m;
    if (!m_valid) begin
      e.reg_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
      e.branch = 1'b0; e.jump = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input instr_t i, input bit v, input bit er, input bit fl);
    cur_id = i;
    id_valid = v; ex_ready = er; flush = fl;
    id_pc = i.pc; id_rs1_data = i.rs1_data; id_rs2_data = i.rs2_data; id_imm = i.imm;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_funct3 = i.funct3;
    id_funct7b5 = i.funct7b5; id_valid_reg = i.valid_reg; id_alu_op = i.alu_op;
    id_reg_src = i.reg_src; id_alu_src = i.alu_src; id_reg_write = i.reg_write;
    id_mem_read = i.mem_read; id_mem_write = i.mem_write; id_branch = i.branch;
    id_jump = i.jump;
  endtask

  // One clock: predict acceptance from the held slot, then advance the slot model.
  task automatic cycle();
    bit hz, free, rdy;
    #1;
    free = !m_valid || ex_ready;
    hz = m_valid && m.mem_read && m.valid_reg[0] && (m.rd != 0) && id_valid &&
         ((cur_id.valid_reg[1] && cur_id.rs1 == m.rd) || (cur_id.valid_reg[2] && cur_id.rs2 == m.rd));
    rdy = free && !hz && !flush;
    seen_ready = id_ready;
    check("id_ready", {159'd0, id_ready}, {159'd0, rdy});
    @(posedge clk);
    if (hz && free && !flush && m_bub != 32'hffff_ffff) m_bub++;
    if (flush && m_valid && m_flu != 32'hffff_ffff) m_flu++;
    if (flush) m_valid = 1'b0;
    else if (id_valid && rdy) begin m = cur_id; m_valid = 1'b1; end
    else if (free) m_valid = 1'b0;
    #1;
    check("ex_valid", {159'd0, ex_valid}, {159'd0, m_valid});
    check("ex_bundle", obs_bundle(), exp_bundle());
`ifdef ID_EX_PERF_EN
    check("perf_bubble", {128'd0, perf_bubble_cnt}, {128'd0, m_bub});
    check("perf_flush", {128'd0, perf_flush_cnt}, {128'd0, m_flu});
`endif
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ex_valid", {159'd0, ex_valid}, 160'd0);
    check("rst_bundle", obs_bundle(), 160'd0);
    m = '0; m_valid = 1'b0; m_bub = '0; m_flu = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle();
    drive(mk(K_ILL, 0, 0, 0), 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    idle();
    @(negedge clk);
    apply_reset();

    // Back-to-back independent ALU ops
    drive(mk(K_ADD, 3, 1, 2), 1, 1, 0); cycle();
    check("t2_acc_first", {159'd0, seen_ready}, 160'd1);
    check("t2_rd_first", {155'd0, ex_rd}, 160'd3);
    drive(mk(K_ADD, 4, 3, 2), 1, 1, 0); cycle();
    check("t2_acc_second", {159'd0, seen_ready}, 160'd1);
    check("t2_rd_second", {155'd0, ex_rd}, 160'd4);

    // Load followed by dependent ADD: exactly one bubble
    drive(mk(K_LW, 5, 2, 0), 1, 1, 0); cycle();
    drive(mk(K_ADD, 6, 5, 1), 1, 1, 0); cycle();
    check("t3_stall", {159'd0, seen_ready}, 160'd0);
    check("t3_bubble_rw", {159'd0, ex_reg_write}, 160'd0);
    cycle();
    check("t3_accept", {159'd0, seen_ready}, 160'd1);
    check("t3_rd", {155'd0, ex_rd}, 160'd6);
`ifdef ID_EX_PERF_EN
    check("t3_bubble_cnt", {128'd0, perf_bubble_cnt}, 160'd1);
`endif

    // rd=x0 never stalls; store reading loaded reg via rs2 does
    drive(mk(K_LW, 0, 2, 0), 1, 1, 0); cycle();
    drive(mk(K_ADD, 6, 0, 1), 1, 1, 0); cycle();
    check("t4_x0_nostall", {159'd0, seen_ready}, 160'd1);
    drive(mk(K_LW, 5, 2, 0), 1, 1, 0); cycle();
    drive(mk(K_SW, 0, 1, 5), 1, 1, 0); cycle();
    check("t4_sw_stall", {159'd0, seen_ready}, 160'd0);
    cycle();
    check("t4_sw_accept", {159'd0, seen_ready}, 160'd1);

    // EX stalled three cycles, flushed in the second
    drive(mk(K_LW, 8, 2, 0), 1, 1, 0); cycle();
    drive(mk(K_ADD, 9, 1, 2), 1, 0, 0); cycle();
    check("t5_hold_ready", {159'd0, seen_ready}, 160'd0);
    check("t5_hold_rd", {155'd0, ex_rd}, 160'd8);
    drive(cur_id, 1, 0, 1); cycle();
    check("t5_flush_ready", {159'd0, seen_ready}, 160'd0);
    check("t5_flush_kill", {159'd0, ex_valid}, 160'd0);
    drive(cur_id, 1, 0, 0); cycle();

    // Rs-less LUI after load; illegal opcode passes as NOP
    drive(mk(K_LW, 7, 2, 0), 1, 1, 0); cycle();
    drive(mk(K_LUI, 7, 7, 7), 1, 1, 0); cycle();
    check("t6_lui_nostall", {159'd0, seen_ready}, 160'd1);
    drive(mk(K_ILL, 7, 7, 7), 1, 1, 0); cycle();
    check("t6_ill_valid", {159'd0, ex_valid}, 160'd1);
    check("t6_ill_rw", {159'd0, ex_reg_write}, 160'd0);

    // Mid-run reset with a live instruction held
    apply_reset();

    for (int n = 0; n < 600; n++) begin
      drive(mk($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
